// File: rtl/key_conditioner.sv
// Per-key conditioner for active-low push buttons: two-flop synchroniser,
// counter debounce, and registered press / release / auto-repeat strobes.
module key_conditioner #(
   parameter int NKEYS        = 2,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DLY   = 25000000,
   parameter int REPEAT_PER   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] key,
   output logic [NKEYS-1:0] pressed,
   output logic [NKEYS-1:0] press,
   output logic [NKEYS-1:0] rel,
   output logic [NKEYS-1:0] rpt
);

   localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DC_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DELAY  = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      logic          sync1;
      logic          sync2;
      logic          st;
      logic [DW-1:0] dc;
      logic [1:0]    state;
      logic [RW-1:0] rc;
      logic          press_r;
      logic          rel_r;
      logic          rpt_r;
      logic          held;
      logic          differ;
      logic          accept;
      logic          go_press;
      logic          go_rel;
      logic          rpt_fire;

      // The raw key is active-low; everything past the synchroniser uses 1 = held.
      always_comb begin
         held     = ~sync2;
         differ   = (held != st);
         accept   = differ && (dc == DC_LAST);
         go_press = accept && !st;
         go_rel   = accept && st;
         rpt_fire = 1'b0;
         if ((REPEAT_EN != 0) && !go_rel) begin
            rpt_fire = ((state == S_DELAY)  && (rc == DLY_LAST)) ||
                       ((state == S_REPEAT) && (rc == PER_LAST));
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            st      <= 1'b0;
            dc      <= '0;
            state   <= S_IDLE;
            rc      <= '0;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
            rpt_r   <= 1'b0;
         end else begin
            sync1   <= key[i];
            sync2   <= sync1;
            press_r <= go_press;
            rel_r   <= go_rel;
            rpt_r   <= rpt_fire;

            if (!differ) begin
               dc <= '0;
            end else if (accept) begin
               dc <= '0;
               st <= ~st;
            end else begin
               dc <= dc + 1'b1;
            end

            // A release wins over a coinciding repeat tick.
            case (state)
               S_IDLE: begin
                  rc <= '0;
                  if (go_press && (REPEAT_EN != 0)) state <= S_DELAY;
               end
               S_DELAY: begin
                  if (go_rel) begin
                     state <= S_IDLE;
                     rc    <= '0;
                  end else if (rc == DLY_LAST) begin
                     state <= S_REPEAT;
                     rc    <= '0;
                  end else begin
                     rc <= rc + 1'b1;
                  end
               end
               S_REPEAT: begin
                  if (go_rel) begin
                     state <= S_IDLE;
                     rc    <= '0;
                  end else if (rc == PER_LAST) begin
                     rc <= '0;
                  end else begin
                     rc <= rc + 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  rc    <= '0;
               end
            endcase
         end
      end

      assign pressed[i] = st;
      assign press[i]   = press_r;
      assign rel[i]     = rel_r;
      assign rpt[i]     = rpt_r;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3.
module tb_key_conditioner;

   logic       clk;
   logic       rst;
   logic [1:0] key;
   logic [1:0] pressed;
   logic [1:0] press;
   logic [1:0] rel;
   logic [1:0] rpt;

   int n_tests;
   int n_fail;

   logic [3:0] exp_q[$];

   key_conditioner #(
      .NKEYS        (2),
      .DEBOUNCE_CYC (4),
      .REPEAT_EN    (1),
      .REPEAT_DLY   (10),
      .REPEAT_PER   (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .key     (key),
      .pressed (pressed),
      .press   (press),
      .rel     (rel),
      .rpt     (rpt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {pressed, press, rel, rpt} after edge k for a press accepted at
   // edge p and a release accepted at edge r (negative = never).
   function automatic logic [3:0] exp_ch(input int k, input int p, input int r);
      logic hold;
      logic tick;
      hold = (p > 0) && (k >= p) && ((r < 0) || (k < r));
      tick = hold && (k >= p + 10) && (((k - p - 10) % 3) == 0);
      return {hold, (k == p), (k == r), tick};
   endfunction

   function automatic logic [3:0] obs(input int i);
      return {pressed[i], press[i], rel[i], rpt[i]};
   endfunction

   task automatic compare_cycle(input string name, input int k);
      for (int i = 0; i < 2; i++) begin
         logic [3:0] e;
         e = exp_q.pop_front();
         check($sformatf("%s key%0d cyc%0d", name, i, k), 32'(obs(i)), 32'(e));
      end
   endtask

   // Key i is held low from edge lo_i up to (not including) edge hi_i.
   task automatic run_window(input string name, input int n,
                             input int lo0, input int hi0, input int lo1, input int hi1,
                             input int p0, input int r0, input int p1, input int r1);
      for (int k = 1; k <= n; k++) begin
         key[0] = (lo0 > 0 && k >= lo0 && k < hi0) ? 1'b0 : 1'b1;
         key[1] = (lo1 > 0 && k >= lo1 && k < hi1) ? 1'b0 : 1'b1;
         exp_q.push_back(exp_ch(k, p0, r0));
         exp_q.push_back(exp_ch(k, p1, r1));
         step();
         compare_cycle(name, k);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      key     = 2'b11;
      step();
      step();
      check("reset outputs", 32'({pressed, press, rel, rpt}), 32'h0);
      rst = 1'b0;

      run_window("clean", 50, 5, 40, -1, -1, 10, 45, -1, -1);

      // 3-cycle low/high bursts never survive a 4-cycle debounce
      for (int k = 1; k <= 40; k++) begin
         key[0] = (k <= 30 && (((k - 1) / 3) % 2) == 0) ? 1'b0 : 1'b1;
         key[1] = 1'b1;
         exp_q.push_back(4'h0);
         exp_q.push_back(4'h0);
         step();
         compare_cycle("bounce", k);
      end

      // release accepted at 35, the edge a repeat tick would otherwise land on
      run_window("repeat", 42, 5, 30, -1, -1, 10, 35, -1, -1);
      run_window("rel_in_delay", 25, 5, 13, -1, -1, 10, 18, -1, -1);
      run_window("simul", 50, 5, 40, 5, 27, 10, 45, 10, 32);

      // reset for edges 24..25 while key[0] is in the repeat phase
      for (int k = 1; k <= 60; k++) begin
         key[0] = (k >= 5 && k < 46) ? 1'b0 : 1'b1;
         key[1] = 1'b1;
         rst    = (k == 24 || k == 25) ? 1'b1 : 1'b0;
         if (k < 24) begin
            exp_q.push_back(exp_ch(k, 10, -1));
         end else if (k <= 25) begin
            exp_q.push_back(4'h0);
         end else begin
            exp_q.push_back(exp_ch(k, 31, 51));
         end
         exp_q.push_back(4'h0);
         step();
         compare_cycle("reset_mid", k);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
